// File: rtl/pc_sequencer.sv
// pc_sequencer: command FSM that orders PC increment/load/branch/save strobes with bus-wait timeout
module pc_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_op,
    input  logic       cond,
    input  logic       bus_valid,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       pc_oe,
    output logic       pc_wr,
    output logic       pc_lhb,
    output logic       pc_inc,
    output logic       pc_off
);
    typedef enum logic [2:0] {IDLE, INC, LD_LO, LD_HI, REL, OUT_LO, OUT_HI, FIN} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             cond_q;
    logic             expire;
    // last idle edge of the wait budget; TIMEOUT=0 never expires
    assign expire = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    // FIN leaves without clk_en so done is exactly one clk wide; all other moves wait for clk_en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            cond_q <= 1'b0;
        end else if (state == FIN) begin
            state <= IDLE;
        end else if (clk_en) begin
            case (state)
                IDLE: if (cmd_valid) begin
                    cond_q <= cond;
                    err_q  <= 1'b0;
                    cnt    <= '0;
                    case (cmd_op)
                        3'd0:       state <= FIN;
                        3'd1:       state <= INC;
                        3'd2, 3'd5: state <= LD_LO;
                        3'd3:       state <= cond ? REL : FIN;
                        3'd4:       state <= OUT_LO;
                        default: begin
                            state <= FIN;
                            err_q <= 1'b1;
                        end
                    endcase
                end
                INC: state <= FIN;
                default: if (bus_valid) begin
                    cnt   <= '0;
                    state <= state == LD_LO ? LD_HI : state == OUT_LO ? OUT_HI : FIN;
                end else if (expire) begin
                    state <= FIN;
                    err_q <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            endcase
        end
    end
    assign cmd_ready = state == IDLE;
    assign busy      = !cmd_ready;
    assign done      = state == FIN;
    assign err       = done && err_q;
    assign pc_oe     = state == OUT_LO || state == OUT_HI;
    assign pc_wr     = (state == LD_LO || state == LD_HI) && bus_valid;
    assign pc_lhb    = state == LD_HI || state == OUT_HI;
    assign pc_inc    = state == INC;
    assign pc_off    = state == REL && bus_valid && cond_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed tests of pc_sequencer against a bench-side 16-bit PC and bus model
module tb_pc_sequencer;
    logic       clk = 0, rst = 1, clk_en = 1, cmd_valid = 0, cond = 0, bus_valid = 0;
    logic [2:0] cmd_op = 0;
    logic [7:0] bus_in = 0;
    logic       cmd_ready, busy, done, err, pc_oe, pc_wr, pc_lhb, pc_inc, pc_off;
    bit   [15:0] pc = 16'hFE00, pc_next = 16'hFE00;
    logic [7:0] bus;
    int checks = 0, errors = 0;
    int n_done = 0, n_err = 0, n_wr = 0, n_inc = 0, n_off = 0, n_oe = 0, n_bad = 0;

    pc_sequencer #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cond(cond), .bus_valid(bus_valid), .cmd_ready(cmd_ready), .busy(busy), .done(done),
        .err(err), .pc_oe(pc_oe), .pc_wr(pc_wr), .pc_lhb(pc_lhb), .pc_inc(pc_inc), .pc_off(pc_off)
    );

    always #5 clk = ~clk;

    assign bus = pc_oe ? (pc_lhb ? pc[15:8] : pc[7:0]) : bus_in;

    // strobe monitor and PC model: inputs are stable mid-cycle, so evaluate on the falling edge
    always @(negedge clk) begin
        pc_next = pc;
        if (!rst) begin
            if (!$onehot0({pc_oe, pc_wr, pc_inc, pc_off})) n_bad++;
            n_done += int'(done);
            n_err  += int'(err);
            n_wr   += int'(pc_wr);
            n_inc  += int'(pc_inc);
            n_off  += int'(pc_off);
            n_oe   += int'(pc_oe);
            if (clk_en) begin
                if (pc_inc) pc_next = pc + 16'd1;
                if (pc_wr && pc_lhb) pc_next = {bus, pc[7:0]};
                if (pc_wr && !pc_lhb) pc_next = {pc[15:8], bus};
                if (pc_off) pc_next = pc + {{8{bus[7]}}, bus};
            end
        end
    end

    // the PC itself commits on the rising edge
    always @(posedge clk) pc <= pc_next;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic c);
        cmd_valid = 1;
        cmd_op = op;
        cond = c;
        step;
        cmd_valid = 0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({cmd_ready, busy, done, err, pc_oe, pc_wr, pc_lhb, pc_inc, pc_off} !== 9'b100000000) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=100000000",
                     {cmd_ready, busy, done, err, pc_oe, pc_wr, pc_lhb, pc_inc, pc_off});
        end
        step;
        rst = 0;
        step;
    endtask

    task automatic test_inc;
        int d0 = n_done, i0 = n_inc;
        issue(3'd1, 0);
        checks++;
        if (pc_inc !== 1 || busy !== 1) begin errors++; $display("FAIL inc_strobe got inc=%b busy=%b want 1 1", pc_inc, busy); end
        step;
        checks++;
        if (done !== 1 || err !== 0) begin errors++; $display("FAIL inc_done got done=%b err=%b want 1 0", done, err); end
        step;
        checks++;
        if (cmd_ready !== 1) begin errors++; $display("FAIL inc_ready got %b want 1", cmd_ready); end
        checks++;
        if (pc !== 16'hFE01) begin errors++; $display("FAIL inc_pc got %h want fe01", pc); end
        checks++;
        if (n_inc - i0 != 1 || n_done - d0 != 1) begin
            errors++;
            $display("FAIL inc_counts got inc=%0d done=%0d want 1 1", n_inc - i0, n_done - d0);
        end
    endtask

    task automatic test_jmp;
        int e0 = n_err;
        bus_in = 8'h34;
        bus_valid = 1;
        issue(3'd2, 0);
        checks++;
        if (pc_wr !== 1 || pc_lhb !== 0) begin errors++; $display("FAIL jmp_lo got wr=%b lhb=%b want 1 0", pc_wr, pc_lhb); end
        step;
        bus_in = 8'h12;
        checks++;
        if (pc_wr !== 1 || pc_lhb !== 1) begin errors++; $display("FAIL jmp_hi got wr=%b lhb=%b want 1 1", pc_wr, pc_lhb); end
        step;
        bus_valid = 0;
        checks++;
        if (done !== 1 || err !== 0) begin errors++; $display("FAIL jmp_done got done=%b err=%b want 1 0", done, err); end
        step;
        checks++;
        if (pc !== 16'h1234 || n_err != e0) begin errors++; $display("FAIL jmp_pc got %h errs=%0d want 1234 0", pc, n_err - e0); end
    endtask

    task automatic test_brel;
        int o0 = n_off;
        bus_in = 8'hF0;
        bus_valid = 1;
        issue(3'd3, 1);
        checks++;
        if (pc_off !== 1) begin errors++; $display("FAIL brel_off got %b want 1", pc_off); end
        step;
        bus_valid = 0;
        checks++;
        if (done !== 1) begin errors++; $display("FAIL brel_done got %b want 1", done); end
        step;
        checks++;
        if (pc !== 16'h1224 || n_off - o0 != 1) begin errors++; $display("FAIL brel_pc got %h offs=%0d want 1224 1", pc, n_off - o0); end
        o0 = n_off;
        bus_valid = 1;
        issue(3'd3, 0);
        checks++;
        if (done !== 1 || err !== 0) begin errors++; $display("FAIL brel0_done got done=%b err=%b want 1 0", done, err); end
        step;
        bus_valid = 0;
        checks++;
        if (pc !== 16'h1224 || n_off != o0 || cmd_ready !== 1) begin
            errors++;
            $display("FAIL brel0_pc got %h offs=%0d ready=%b want 1224 0 1", pc, n_off - o0, cmd_ready);
        end
    endtask

    task automatic test_save;
        bus_in = 8'hCD;
        bus_valid = 1;
        issue(3'd5, 0);
        step;
        bus_in = 8'hAB;
        step;
        bus_valid = 0;
        step;
        checks++;
        if (pc !== 16'hABCD) begin errors++; $display("FAIL restore_pc got %h want abcd", pc); end
        bus_in = 8'h00;
        issue(3'd4, 0);
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 3; k++) step;
            checks++;
            if (pc_oe !== 1 || pc_lhb !== 1'(b) || bus !== (b == 1 ? 8'hAB : 8'hCD)) begin
                errors++;
                $display("FAIL save_byte%0d got oe=%b lhb=%b bus=%h", b, pc_oe, pc_lhb, bus);
            end
            bus_valid = 1;
            step;
            bus_valid = 0;
        end
        checks++;
        if (done !== 1 || err !== 0 || pc_oe !== 0) begin
            errors++;
            $display("FAIL save_done got done=%b err=%b oe=%b want 1 0 0", done, err, pc_oe);
        end
        step;
    endtask

    task automatic test_timeout;
        int w0 = n_wr, n = 0, en = 0;
        issue(3'd2, 0);
        while (!done && n < 100) begin step; n++; end
        checks++;
        if (n != 16 || err !== 1 || n_wr != w0) begin
            errors++;
            $display("FAIL timeout got cycles=%0d err=%b wr=%0d want 16 1 0", n, err, n_wr - w0);
        end
        step;
        checks++;
        if (cmd_ready !== 1) begin errors++; $display("FAIL timeout_idle got %b want 1", cmd_ready); end
        n = 0;
        issue(3'd2, 0);
        while (!done && n < 100) begin
            clk_en = n[0];
            step;
            en += int'(clk_en);
            n++;
        end
        clk_en = 1;
        checks++;
        if (en != 16 || n != 32 || err !== 1 || n_wr != w0) begin
            errors++;
            $display("FAIL timeout_gated got en=%0d total=%0d err=%b wr=%0d want 16 32 1 0", en, n, err, n_wr - w0);
        end
        step;
    endtask

    task automatic test_illegal;
        int w0 = n_wr, i0 = n_inc, o0 = n_off, e0 = n_oe;
        issue(3'd7, 0);
        checks++;
        if (done !== 1 || err !== 1) begin errors++; $display("FAIL illegal_err got done=%b err=%b want 1 1", done, err); end
        step;
        checks++;
        if (n_wr != w0 || n_inc != i0 || n_off != o0 || n_oe != e0 || cmd_ready !== 1) begin
            errors++;
            $display("FAIL illegal_strobes got strobes=%0d ready=%b want 0 1",
                     n_wr - w0 + n_inc - i0 + n_off - o0 + n_oe - e0, cmd_ready);
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        bus_in = 8'h34;
        bus_valid = 1;
        issue(3'd2, 0);
        step;
        bus_valid = 0;
        checks++;
        if (pc_lhb !== 1 || busy !== 1) begin errors++; $display("FAIL rstmid_state got lhb=%b busy=%b want 1 1", pc_lhb, busy); end
        rst = 1;
        #1;
        checks++;
        if ({pc_oe, pc_wr, pc_lhb, pc_inc, pc_off, done, cmd_ready} !== 7'b0000001) begin
            errors++;
            $display("FAIL rstmid_async got %b want 0000001", {pc_oe, pc_wr, pc_lhb, pc_inc, pc_off, done, cmd_ready});
        end
        step;
        rst = 0;
        d0 = n_done;
        for (int k = 0; k < 3; k++) step;
        checks++;
        if (n_done != d0) begin errors++; $display("FAIL rstmid_nodone got %0d want 0", n_done - d0); end
        issue(3'd1, 0);
        step;
        step;
        checks++;
        if (pc !== 16'hAB35 || n_done != d0 + 1 || cmd_ready !== 1) begin
            errors++;
            $display("FAIL rstmid_inc got pc=%h done=%0d ready=%b want ab35 1 1", pc, n_done - d0, cmd_ready);
        end
    endtask

    task automatic test_onehot;
        checks++;
        if (n_bad != 0) begin errors++; $display("FAIL onehot0 got %0d bad cycles want 0", n_bad); end
    endtask

    initial begin
        test_reset;
        test_inc;
        test_jmp;
        test_brel;
        test_save;
        test_timeout;
        test_illegal;
        test_reset_mid;
        test_onehot;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
